// File: rtl/msrv32_alu_pkg.sv
// msrv32_alu_pkg: shared definitions for the ALU and its arbiter.
//   ALU_WIDTH        - default datapath width
//   ALU_* constants  - 4-bit ALU opcode encodings
//   is_legal_opcode  - 1 for any of the ten implemented opcodes
package msrv32_alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  function automatic logic is_legal_opcode(input logic [3:0] opc);
    logic legal;
    case (opc)
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
      ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/msrv32_alu.sv
// msrv32_alu: combinational integer ALU.
//   op_1_in, op_2_in - operands (WIDTH bits)
//   opcode_in        - 4-bit opcode from msrv32_alu_pkg
//   result_out       - result; 0 for unimplemented opcodes
// Shifts use op_2_in[4:0]; add/sub wrap modulo 2^WIDTH.
module msrv32_alu
  import msrv32_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] op_1_in,
  input  logic [WIDTH-1:0] op_2_in,
  input  logic [3:0]       opcode_in,
  output logic [WIDTH-1:0] result_out
);

  logic [4:0] shamt;
  assign shamt = op_2_in[4:0];

  always_comb begin
    result_out = '0;
    case (opcode_in)
      ALU_ADD:  result_out = op_1_in + op_2_in;
      ALU_SUB:  result_out = op_1_in - op_2_in;
      ALU_SLT:  result_out = {{(WIDTH-1){1'b0}}, ($signed(op_1_in) < $signed(op_2_in))};
      ALU_SLTU: result_out = {{(WIDTH-1){1'b0}}, (op_1_in < op_2_in)};
      ALU_AND:  result_out = op_1_in & op_2_in;
      ALU_OR:   result_out = op_1_in | op_2_in;
      ALU_XOR:  result_out = op_1_in ^ op_2_in;
      ALU_SLL:  result_out = op_1_in << shamt;
      ALU_SRL:  result_out = op_1_in >> shamt;
      ALU_SRA:  result_out = $signed(op_1_in) >>> shamt;
      default:  result_out = '0;
    endcase
  end

endmodule

// File: rtl/msrv32_rr_pick.sv
// msrv32_rr_pick: combinational round-robin winner selection.
//   req_in    - request vector (NUM_REQ bits)
//   ptr_in    - highest-priority index this cycle
//   grant_out - one-hot winner, '0 when nothing requests
//   idx_out   - index of the winner
//   any_out   - 1 when a winner exists
module msrv32_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [ID_W-1:0]    ptr_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [ID_W-1:0]    idx_out,
  output logic               any_out
);

  // First pass covers indices at or above the pointer, second pass the
  // wrapped-around lower indices; the first hit wins.
  always_comb begin
    grant_out = '0;
    idx_out   = '0;
    any_out   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_out && req_in[i] && (i >= 32'(ptr_in))) begin
        any_out      = 1'b1;
        grant_out[i] = 1'b1;
        idx_out      = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_out && req_in[i]) begin
        any_out      = 1'b1;
        grant_out[i] = 1'b1;
        idx_out      = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/msrv32_alu_arbiter.sv
// msrv32_alu_arbiter: shares one msrv32_alu between NUM_REQ requesters with
// a round-robin valid/ready arbiter and a two-stage pipeline
// (S1 operand register -> ALU -> S2 result register).
//   clk_in, rst_in     - clock, asynchronous active-high reset
//   req_valid_in       - per-requester valid
//   req_op1_in/op2_in  - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_opcode_in      - packed 4-bit opcodes, requester i at [i*4 +: 4]
//   req_ready_out      - one-hot grant (accept = valid & ready at clk edge)
//   rsp_valid_out      - result valid
//   rsp_id_out         - requester index owning the result
//   rsp_result_out     - ALU result (0 for unimplemented opcodes)
//   rsp_ready_in       - consumer accepts the result
// Optional build macro MSRV32_ALU_ARB_LOCK_EN adds req_lock_in: an accepted
// requester with its lock bit set keeps the round-robin pointer.
module msrv32_alu_arbiter
  import msrv32_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op1_in,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op2_in,
  input  logic [NUM_REQ*4-1:0]       req_opcode_in,
`ifdef MSRV32_ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock_in,
`endif
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic                       rsp_valid_out,
  output logic [ID_W-1:0]            rsp_id_out,
  output logic [WIDTH-1:0]           rsp_result_out,
  input  logic                       rsp_ready_in
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic               accept;

  logic               s1_v;
  logic [WIDTH-1:0]   s1_op1;
  logic [WIDTH-1:0]   s1_op2;
  logic [3:0]         s1_opc;
  logic [ID_W-1:0]    s1_id;

  logic               s2_v;
  logic [WIDTH-1:0]   s2_result;
  logic [ID_W-1:0]    s2_id;

  logic               s1_adv;
  logic               s2_adv;
  logic [WIDTH-1:0]   alu_result;

  logic [WIDTH-1:0]   op1_arr [NUM_REQ];
  logic [WIDTH-1:0]   op2_arr [NUM_REQ];
  logic [3:0]         opc_arr [NUM_REQ];
  logic [WIDTH-1:0]   sel_op1;
  logic [WIDTH-1:0]   sel_op2;
  logic [3:0]         sel_opc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op1_arr[g] = req_op1_in[g*WIDTH +: WIDTH];
    assign op2_arr[g] = req_op2_in[g*WIDTH +: WIDTH];
    assign opc_arr[g] = req_opcode_in[g*4 +: 4];
  end

  msrv32_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_in    (req_valid_in),
    .ptr_in    (rr_ptr),
    .grant_out (win_onehot),
    .idx_out   (win_idx),
    .any_out   (win_any)
  );

  msrv32_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op_1_in    (s1_op1),
    .op_2_in    (s1_op2),
    .opcode_in  (s1_opc),
    .result_out (alu_result)
  );

  assign s2_adv = ~s2_v | rsp_ready_in;
  assign s1_adv = ~s1_v | s2_adv;

  // Grant is held low during reset so nothing is accepted into a stage
  // that is being cleared.
  assign req_ready_out = (s1_adv && !rst_in) ? win_onehot : '0;
  assign accept        = |req_ready_out;

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    sel_opc = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_op1 = op1_arr[i];
        sel_op2 = op2_arr[i];
        sel_opc = opc_arr[i];
      end
    end
  end

  always_comb begin
    ptr_nxt = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`ifdef MSRV32_ALU_ARB_LOCK_EN
    if (|(req_lock_in & win_onehot)) begin
      ptr_nxt = win_idx;
    end
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr    <= '0;
      s1_v      <= 1'b0;
      s1_op1    <= '0;
      s1_op2    <= '0;
      s1_opc    <= '0;
      s1_id     <= '0;
      s2_v      <= 1'b0;
      s2_result <= '0;
      s2_id     <= '0;
    end else begin
      if (s2_adv) begin
        s2_v      <= s1_v;
        s2_result <= is_legal_opcode(s1_opc) ? alu_result : '0;
        s2_id     <= s1_id;
      end
      if (s1_adv) begin
        s1_v   <= win_any;
        s1_op1 <= sel_op1;
        s1_op2 <= sel_op2;
        s1_opc <= sel_opc;
        s1_id  <= win_idx;
      end
      if (accept) begin
        rr_ptr <= ptr_nxt;
      end
    end
  end

  assign rsp_valid_out  = s2_v;
  assign rsp_id_out     = s2_id;
  assign rsp_result_out = s2_result;

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// tb_msrv32_alu_arbiter: scoreboard bench for msrv32_alu_arbiter.
// Directed phases follow the test plan; a random phase follows. A negedge
// monitor predicts grants and responses from an abstract model (pointer,
// queue of in-flight ops) and checks every cycle.
module tb_msrv32_alu_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 3;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ*WIDTH-1:0] req_op1_in;
  logic [NUM_REQ*WIDTH-1:0] req_op2_in;
  logic [NUM_REQ*4-1:0]     req_opcode_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     rsp_valid_out;
  logic [ID_W-1:0]          rsp_id_out;
  logic [WIDTH-1:0]         rsp_result_out;
  logic                     rsp_ready_in;
`ifdef MSRV32_ALU_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock_in;
`endif

  msrv32_alu_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_op1_in     (req_op1_in),
    .req_op2_in     (req_op2_in),
    .req_opcode_in  (req_opcode_in),
`ifdef MSRV32_ALU_ARB_LOCK_EN
    .req_lock_in    (req_lock_in),
`endif
    .req_ready_out  (req_ready_out),
    .rsp_valid_out  (rsp_valid_out),
    .rsp_id_out     (rsp_id_out),
    .rsp_result_out (rsp_result_out),
    .rsp_ready_in   (rsp_ready_in)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned id;
    logic [31:0] res;
    int unsigned acc;
  } item_t;

  item_t       sb[$];
  int unsigned m_ptr  = 0;
  int unsigned edges  = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    sh = int'(b) & 31;
    sa = a;
    case (opc)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return sa >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_winner(input logic [NUM_REQ-1:0] v, input int unsigned ptr);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned j;
      j = (ptr + k) % NUM_REQ;
      if (v[j]) return int'(j);
    end
    return -1;
  endfunction

  // Monitor: inputs are stable at negedge, so this predicts what the next
  // posedge will do. The S1 stage can take an op unless two are in flight
  // and the consumer stalls; the oldest op is visible once one edge has
  // passed since it was accepted.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (rst_in) begin
        chk("rst_ready", 64'(req_ready_out), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id_out), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result_out), 64'd0);
        sb.delete();
        m_ptr = 0;
        edges = 0;
      end else begin
        int w;
        bit can;
        bit exp_v;
        logic [NUM_REQ-1:0] exp_rdy;
        w       = exp_winner(req_valid_in, m_ptr);
        can     = (sb.size() < 2) || rsp_ready_in;
        exp_rdy = '0;
        if (can && w >= 0) exp_rdy[w] = 1'b1;
        chk("grant", 64'(req_ready_out), 64'(exp_rdy));
        exp_v = (sb.size() > 0) && (sb[0].acc < edges);
        chk("rsp_valid", 64'(rsp_valid_out), 64'(exp_v));
        if (exp_v && rsp_valid_out) begin
          chk("rsp_id", 64'(rsp_id_out), 64'(sb[0].id));
          chk("rsp_result", 64'(rsp_result_out), 64'(sb[0].res));
        end
        if (exp_v && rsp_ready_in) void'(sb.pop_front());
        if (can && w >= 0) begin
          item_t it;
          it.id  = w;
          it.res = ref_alu(req_opcode_in[w*4 +: 4], req_op1_in[w*WIDTH +: WIDTH],
                           req_op2_in[w*WIDTH +: WIDTH]);
          it.acc = edges + 1;
          sb.push_back(it);
`ifdef MSRV32_ALU_ARB_LOCK_EN
          if (req_lock_in[w]) m_ptr = w;
          else m_ptr = (w + 1) % NUM_REQ;
`else
          m_ptr = (w + 1) % NUM_REQ;
`endif
        end
        edges++;
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b);
    req_opcode_in[i*4 +: 4]       = opc;
    req_op1_in[i*WIDTH +: WIDTH]  = a;
    req_op2_in[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_in       = 1'b1;
    req_valid_in = '0;
    tick();
    rst_in = 1'b0;
  endtask

  // Single op from requester 0 with an idle pipeline: grant in the issue
  // cycle, response visible after the following edge.
  task automatic run_single(input string name, input logic [3:0] opc, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    int n;
    set_req(0, opc, a, b);
    req_valid_in = 4'b0001;
    rsp_ready_in = 1'b1;
    n = 0;
    @(negedge clk_in);
    while (!req_ready_out[0] && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk({name, "_grant"}, 64'(req_ready_out), 64'd1);
    tick();
    req_valid_in = '0;
    tick();
    chk({name, "_valid"}, 64'(rsp_valid_out), 64'd1);
    chk({name, "_id"}, 64'(rsp_id_out), 64'd0);
    chk({name, "_result"}, 64'(rsp_result_out), 64'(exp));
  endtask

  initial begin
    logic [NUM_REQ-1:0] acc;
    logic [31:0]        held;
    rst_in        = 1'b1;
    req_valid_in  = '0;
    req_op1_in    = '0;
    req_op2_in    = '0;
    req_opcode_in = '0;
    rsp_ready_in  = 1'b1;
`ifdef MSRV32_ALU_ARB_LOCK_EN
    req_lock_in   = '0;
`endif
    mon_en = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;

    // Single request latency and arithmetic corners
    run_single("add", 4'b0000, 32'd5, 32'd7, 32'd12);
    run_single("sub", 4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF);
    run_single("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_single("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_single("sra", 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    run_single("illegal", 4'b1111, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0);
    run_single("srl_shamt", 4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);

    // Round robin with all four valid
    do_reset();
    rsp_ready_in = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'b0000, 32'(i * 100), 32'd1);
    req_valid_in = '1;
    for (int c = 0; c < 5; c++) begin
      logic [NUM_REQ-1:0] e;
      @(negedge clk_in);
      e = '0;
      e[c % NUM_REQ] = 1'b1;
      chk("rr_order", 64'(req_ready_out), 64'(e));
      tick();
      set_req(c % NUM_REQ, 4'b0100, $urandom, $urandom);
    end
    req_valid_in = '0;
    repeat (4) tick();

    // Backpressure: two ops fill the pipe, then everything stalls
    do_reset();
    rsp_ready_in = 1'b0;
    set_req(1, 4'b0000, 32'd1000, 32'd1);
    set_req(2, 4'b0000, 32'd2000, 32'd2);
    req_valid_in = 4'b0110;
    @(negedge clk_in);
    chk("bp_grant1", 64'(req_ready_out), 64'b0010);
    tick();
    @(negedge clk_in);
    chk("bp_grant2", 64'(req_ready_out), 64'b0100);
    tick();
    held = 32'd1001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      chk("bp_ready_low", 64'(req_ready_out), 64'd0);
      chk("bp_hold_id", 64'(rsp_id_out), 64'd1);
      chk("bp_hold_result", 64'(rsp_result_out), 64'(held));
      tick();
    end
    req_valid_in = '0;
    rsp_ready_in = 1'b1;
    @(negedge clk_in);
    chk("bp_out1", 64'({rsp_valid_out, rsp_id_out}), 64'({1'b1, 3'd1}));
    tick();
    @(negedge clk_in);
    chk("bp_out2", 64'({rsp_valid_out, rsp_id_out}), 64'({1'b1, 3'd2}));
    chk("bp_out2_result", 64'(rsp_result_out), 64'd2002);
    repeat (3) tick();

    // Reset with both stages full
    rsp_ready_in = 1'b0;
    set_req(0, 4'b0110, 32'hA0, 32'h0B);
    set_req(3, 4'b0111, 32'hFF, 32'h3C);
    req_valid_in = 4'b1001;
    tick();
    tick();
    tick();
    rst_in       = 1'b1;
    req_valid_in = '0;
    #1;
    chk("midrst_valid_drop", 64'(rsp_valid_out), 64'd0);
    chk("midrst_ready", 64'(req_ready_out), 64'd0);
    tick();
    rst_in       = 1'b0;
    rsp_ready_in = 1'b1;
    req_valid_in = 4'b0101;
    @(negedge clk_in);
    chk("midrst_next_grant", 64'(req_ready_out), 64'b0001);
    tick();
    req_valid_in = 4'b0100;
    tick();
    req_valid_in = '0;
    repeat (4) tick();

`ifdef MSRV32_ALU_ARB_LOCK_EN
    // Lock keeps requester 2 in front until released
    do_reset();
    rsp_ready_in = 1'b1;
    set_req(2, 4'b0000, 32'd2, 32'd2);
    set_req(3, 4'b0000, 32'd3, 32'd3);
    req_valid_in = 4'b1100;
    req_lock_in  = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      chk("lock_grant2", 64'(req_ready_out), 64'b0100);
      tick();
      if (c == 1) req_lock_in = '0;
    end
    @(negedge clk_in);
    chk("lock_release_grant3", 64'(req_ready_out), 64'b1000);
    tick();
    req_valid_in = '0;
    repeat (4) tick();
`endif

    // Random traffic; requesters hold until accepted
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_in);
      acc = req_valid_in & req_ready_out;
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) req_valid_in[i] = 1'b0;
        if (!req_valid_in[i] && $urandom_range(0, 2) != 0) begin
          logic [31:0] a;
          logic [31:0] b;
          a = $urandom;
          b = $urandom;
          if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
          if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
          set_req(i, 4'($urandom_range(0, 15)), a, b);
          req_valid_in[i] = 1'b1;
        end
      end
`ifdef MSRV32_ALU_ARB_LOCK_EN
      req_lock_in = NUM_REQ'($urandom_range(0, 15)) & NUM_REQ'($urandom_range(0, 15));
`endif
      rsp_ready_in = ($urandom_range(0, 3) != 0);
    end

    req_valid_in = '0;
    rsp_ready_in = 1'b1;
    repeat (6) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msrv32_alu_arbiter.md
# msrv32_alu_arbiter

Shares one instance of the team's `msrv32_alu` between `NUM_REQ` requesters using a fair, round-robin, valid/ready arbiter. It has a two-stage pipeline: an operand register, then the ALU, then a result register. Each response returns on a single channel tagged with the requester ID. It sits between the execution-side clients and the ALU, for example the main datapath, the address-generation helper and the CSR unit.

## Interface
- `WIDTH`, 32: operand and result width.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 3: width of the requester ID; must satisfy 2^ID_W ≥ NUM_REQ.
- `clk_in` input 1: the single clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `req_valid_in` input NUM_REQ: per-requester request valid.
- `req_op1_in` input NUM_REQ*WIDTH: packed operand 1; requester i uses slice [i*WIDTH +: WIDTH].
- `req_op2_in` input NUM_REQ*WIDTH: packed operand 2, same slicing.
- `req_opcode_in` input NUM_REQ*4: packed 4-bit ALU opcodes.
- `req_ready_out` output NUM_REQ: grant; at most one bit is high in any cycle.
- `rsp_valid_out` output 1: result valid.
- `rsp_id_out` output ID_W: index of the requester that owns the result.
- `rsp_result_out` output WIDTH: ALU result.
- `rsp_ready_in` input 1: consumer accepts the result.

## Operation
- **Accept rule:** a request from i is accepted when `req_valid_in[i] & req_ready_out[i]` is high at a rising edge.
  - The requester must hold valid, operands and opcode stable until accepted.
  - `req_valid_in` must not depend on `req_ready_out`.
- **Stage S1 (operand register):** holds op1, op2, opcode, id and `s1_v`.
- **Stage S2 (result register):** holds the ALU result, id and `s2_v`.
- **S2 advance:** `s2_adv = ~s2_v | rsp_ready_in`.
  - On an S2 advance, S2 loads from S1: `s2_v <= s1_v`.
- **S1 advance:** `s1_adv = ~s1_v | s2_adv`.
  - On an S1 advance, S1 loads the winner, if any: `s1_v <= |grant`.
- **Grant:** `req_ready_out = s1_adv ? onehot_winner : 0`.
  - The winner is the first valid requester at or after `rr_ptr`, searching upward and wrapping at NUM_REQ-1 → 0.
- **Pointer update:** on an accepted grant to i, `rr_ptr <= (i == NUM_REQ-1) ? 0 : i+1`.
  - With no accept, the pointer holds.
- **ALU interface:** the ALU takes opcodes ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101.
  - The arbiter forces the S2 load to 0 for any other opcode.
  - SLT is a full signed less-than: `$signed(op1) < $signed(op2)`, result is 1 or 0 zero-extended.
  - Shifts use `op2[4:0]`.
  - Arithmetic wraps modulo 2^WIDTH.
- **Outputs:** `rsp_valid_out = s2_v`; `rsp_id_out` and `rsp_result_out` are driven directly from S2 registers.
- **Backpressure:** with both stages full and `rsp_ready_in=0`, all ready bits are 0 and nothing moves.
- **Simultaneous events:** a response being consumed and a new request being accepted in the same cycle proceed together, so full throughput is 1 op/cycle.
- **Reset:** asserting `rst_in` at any time, including mid-operation, clears `s1_v`, `s2_v`, `rr_ptr` (to 0) and all S2 data (to 0).
  - In-flight operations are discarded; no response is produced for them.

## Timing
- **Reset values:** `req_ready_out` = 0 while `rst_in` is high, then combinational from the first cycle after release. `rsp_valid_out` = 0, `rsp_id_out` = 0, `rsp_result_out` = 0.
- **Latency:** a request accepted at edge k shows `rsp_valid_out` = 1 after edge k+1, i.e. 2 cycles, when there is no stall.
  - Each cycle of S2 stall adds one cycle.
- **Response hold:** `rsp_*` holds stable while `rsp_valid_out & ~rsp_ready_in`.
- **Combinational path:** `req_ready_out` depends on `req_valid_in`, `rr_ptr`, `s1_v`, `s2_v` and `rsp_ready_in`.

## Configuration
- **`MSRV32_ALU_ARB_LOCK_EN` defined:** adds input `req_lock_in` (NUM_REQ).
  - When the accepted requester i has `req_lock_in[i]=1`, `rr_ptr <= i` instead of advancing, so i keeps priority for back-to-back ops.
  - Lock is ignored in cycles with no accept.
- **`MSRV32_ALU_ARB_LOCK_EN` undefined:** the port is absent and the pointer always advances as above.

## Structure
- **Package `msrv32_alu_pkg`:**
  - the ten ALU opcode constants;
  - WIDTH default;
  - an `is_legal_opcode` function.
- **Sub-module `msrv32_rr_pick`:** combinational; takes the request vector and pointer and returns the one-hot winner plus its index.
  - The arbiter instantiates it together with `msrv32_alu`.

## Test plan
- **Single request, latency:** after reset, req0 sends ADD 5+7 → `req_ready_out[0]` is 1 in that cycle; `rsp_valid_out`=1, id=0, result=12 two cycles later.
- **Round-robin sequence:** all four valid continuously with `rsp_ready_in`=1 → grants go 0,1,2,3,0 on consecutive cycles and responses stream 1/cycle with matching IDs.
- **Backpressure:** `rsp_ready_in`=0 for 5 cycles with req1 and req2 valid → two ops are accepted, then all ready bits are 0.
  - Response holds id=1 and its result unchanged.
  - On release, id=1 then id=2 stream out with no loss.
- **Arithmetic corners:**
  - SUB 0−1 → 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU same operands → 0.
  - SRA 0x80000000 by 31 → 0xFFFFFFFF.
  - Opcode 1111 → 0.
- **Reset mid-operation:** `rst_in` pulsed with both stages full → `rsp_valid_out` drops immediately, no stale response appears, and the next grant goes to requester 0.
- **Lock (macro defined):** req2 valid with lock=1 alongside req3 → req2 is granted on three consecutive cycles; dropping the lock lets req3 win next.
